// File: rtl/key_schedule_pkg.sv
// Shared DES key-schedule constants and the fixed PC-1 / PC-2 permutations.
//   state_t  : FSM encoding (IDLE=0, RUN=1, DONE=2)
//   SHIFT    : per-round rotate amount, SHIFT[0] is round 1
//   perm_pc1 : 64-bit key -> 56-bit C||D, parity bits dropped
//   perm_pc2 : 56-bit C||D -> 48-bit round key
package key_schedule_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Tables use DES numbering: bit 1 is the MSB of the source word.
    localparam logic [7:0] PC1_TBL [56] = '{
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,
        8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,
        8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
        8'd60, 8'd52, 8'd44, 8'd36,
        8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7,
        8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,
        8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,
        8'd28, 8'd20, 8'd12, 8'd4
    };

    localparam logic [7:0] PC2_TBL [48] = '{
        8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,  8'd3,  8'd28,
        8'd15, 8'd6,  8'd21, 8'd10, 8'd23, 8'd19, 8'd12, 8'd4,
        8'd26, 8'd8,  8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
        8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55, 8'd30, 8'd40,
        8'd51, 8'd45, 8'd33, 8'd48, 8'd44, 8'd49, 8'd39, 8'd56,
        8'd34, 8'd53, 8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
    };

    function automatic logic [55:0] perm_pc1(input logic [63:0] kin);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++)
            o[6'(55 - i)] = kin[6'(64 - int'(PC1_TBL[6'(i)]))];
        return o;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++)
            o[6'(47 - i)] = cd[6'(56 - int'(PC2_TBL[6'(i)]))];
        return o;
    endfunction

endpackage

// File: rtl/key_schedule_if.sv
// Consumer <-> key-schedule bundle.
//   master : consumer side, drives req/dec/key/nxt, sees k/rnd/k_vld/busy/done
//   slave  : key_schedule side
interface key_schedule_if;
    logic        req;
    logic        dec;
    logic [63:0] key;
    logic        nxt;
    logic [47:0] k;
    logic [3:0]  rnd;
    logic        k_vld;
    logic        busy;
    logic        done;

    modport master (output req, dec, key, nxt,
                    input  k, rnd, k_vld, busy, done);
    modport slave  (input  req, dec, key, nxt,
                    output k, rnd, k_vld, busy, done);
endinterface

// File: rtl/key_schedule_rot28.sv
// Combinational rotate of one 28-bit DES key half.
//   din_i  : half to rotate
//   dir_i  : 0 = left, 1 = right
//   amt_i  : 1 or 2 (anything other than 2 rotates by 1)
//   dout_o : rotated half
module key_rot28 (
    input  logic [27:0] din_i,
    input  logic        dir_i,
    input  logic [1:0]  amt_i,
    output logic [27:0] dout_o
);
    always_comb begin
        dout_o = din_i;
        case ({dir_i, amt_i == 2'd2})
            2'b00:   dout_o = {din_i[26:0], din_i[27]};
            2'b01:   dout_o = {din_i[25:0], din_i[27:26]};
            2'b10:   dout_o = {din_i[0],    din_i[27:1]};
            default: dout_o = {din_i[1:0],  din_i[27:2]};
        endcase
    end
endmodule

// File: rtl/key_schedule.sv
// Iterative DES key schedule: serves the 16 round keys one per nxt strobe,
// K1..K16 for encrypt, K16..K1 for decrypt.
//   clk : clock
//   rst : asynchronous active-low reset
//   ks  : slave side of key_schedule_if (req/dec/key/nxt in, k/rnd/k_vld/busy/done out)
module key_schedule
    import key_schedule_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    key_schedule_if.slave ks
);
    state_t      state_q;
    logic [27:0] c_q, d_q;
    logic [3:0]  rnd_q;
    logic        dec_q;

    logic [55:0] pc1;
    logic [27:0] c_src, d_src, c_d, d_d;
    logic        rot_dir;
    logic [1:0]  rot_amt;

    assign pc1 = perm_pc1(ks.key);

    // One rotator pair serves both the load (rotl 1 of PC-1 for encrypt)
    // and the per-round step, selected by state.
    always_comb begin
        c_src   = c_q;
        d_src   = d_q;
        rot_dir = dec_q;
        rot_amt = dec_q ? SHIFT[4'd15 - rnd_q] : SHIFT[rnd_q + 4'd1];
        if (state_q == IDLE) begin
            c_src   = pc1[55:28];
            d_src   = pc1[27:0];
            rot_dir = 1'b0;
            rot_amt = 2'd1;
        end
    end

    key_rot28 u_rot_c (.din_i(c_src), .dir_i(rot_dir), .amt_i(rot_amt), .dout_o(c_d));
    key_rot28 u_rot_d (.din_i(d_src), .dir_i(rot_dir), .amt_i(rot_amt), .dout_o(d_d));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            rnd_q   <= '0;
            dec_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (ks.req) begin
                    // Decrypt starts at K16, whose net rotation of 28 is identity.
                    c_q     <= ks.dec ? pc1[55:28] : c_d;
                    d_q     <= ks.dec ? pc1[27:0]  : d_d;
                    dec_q   <= ks.dec;
                    rnd_q   <= '0;
                    state_q <= RUN;
                end
                RUN: if (ks.nxt) begin
                    if (rnd_q == 4'd15) begin
                        state_q <= DONE;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                        c_q   <= c_d;
                        d_q   <= d_d;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ks.k     = perm_pc2({c_q, d_q});
    assign ks.rnd   = rnd_q;
    assign ks.k_vld = (state_q == RUN);
    assign ks.busy  = (state_q == RUN);
    assign ks.done  = (state_q == DONE);
endmodule

// File: tb/tb_key_schedule.sv
module tb_key_schedule;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_schedule_if ifc ();
    key_schedule dut (.clk(clk), .rst(rst), .ks(ifc));

    int tests = 0;
    int fails = 0;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [47:0] K1_A  = 48'h1B02EFFC7072;
    localparam logic [47:0] K16_A = 48'hCB3D8B0E17F5;

    int pc1t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                      63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    int pc2t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                      41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int sht  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    logic [47:0] exp_q [$];
    logic [47:0] seq [16];
    logic [47:0] seq_enc [16];

    // Reference: round r (0-based) key from cumulative left rotation of PC-1.
    function automatic logic [47:0] model_key(input logic [63:0] key, input int r);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] o;
        int s;
        s = 0;
        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - pc1t[i])];
        c = cd[55:28];
        d = cd[27:0];
        for (int j = 0; j <= r; j++) s += sht[j];
        for (int j = 0; j < s; j++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) o[6'(47 - i)] = cd[6'(56 - pc2t[i])];
        return o;
    endfunction

    task automatic do_run(input logic [63:0] key, input logic d, input bit gaps,
                          input bit spam, input bit use_const, input logic [47:0] cval);
        logic [47:0] prev_k, ek;
        logic [3:0]  prev_rnd;
        bit          prev_n, n;
        int          idx, cyc, lat;
        exp_q.delete();
        for (int i = 0; i < 16; i++)
            exp_q.push_back(use_const ? cval : model_key(key, d ? 15 - i : i));
        ifc.req = 1'b1; ifc.dec = d; ifc.key = key; ifc.nxt = 1'b0;
        @(posedge clk); #1;
        ifc.req = spam;
        prev_k = '0; prev_rnd = '0;
        lat = 1; idx = 0; cyc = 0; prev_n = 1'b1;
        while (exp_q.size() != 0 && cyc < 200) begin
            tests++;
            if (ifc.k_vld !== 1'b1 || ifc.busy !== 1'b1) begin
                fails++;
                $display("FAIL run_vld cyc=%0d: k_vld=%b busy=%b, want 1 1", cyc, ifc.k_vld, ifc.busy);
            end
            if (!prev_n) begin
                tests++;
                if (ifc.k !== prev_k || ifc.rnd !== prev_rnd) begin
                    fails++;
                    $display("FAIL hold cyc=%0d: k=%h rnd=%0d, want k=%h rnd=%0d",
                             cyc, ifc.k, ifc.rnd, prev_k, prev_rnd);
                end
            end
            n = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (n) begin
                ek = exp_q.pop_front();
                tests++;
                if (ifc.k !== ek || ifc.rnd !== 4'(idx)) begin
                    fails++;
                    $display("FAIL key idx=%0d dec=%b: k=%h rnd=%0d, want k=%h rnd=%0d",
                             idx, d, ifc.k, ifc.rnd, ek, idx);
                end
                seq[idx] = ifc.k;
                idx++;
            end
            prev_k = ifc.k; prev_rnd = ifc.rnd; prev_n = n;
            ifc.nxt = n;
            if (spam) begin
                ifc.dec = ~ifc.dec;
                ifc.key = {$urandom(), $urandom()};
            end
            @(posedge clk); #1;
            cyc++; lat++;
        end
        ifc.nxt = 1'b0;
        tests++;
        if (cyc >= 200) begin
            fails++;
            $display("FAIL run_timeout: %0d keys left after %0d cycles, want 0", exp_q.size(), cyc);
        end
        tests++;
        if (ifc.done !== 1'b1 || ifc.k_vld !== 1'b0 || ifc.busy !== 1'b0) begin
            fails++;
            $display("FAIL done_state: done=%b k_vld=%b busy=%b, want 1 0 0", ifc.done, ifc.k_vld, ifc.busy);
        end
        if (!gaps) begin
            tests++;
            if (lat != 17) begin
                fails++;
                $display("FAIL done_latency: %0d cycles from first k_vld to done, want 17", lat);
            end
        end
        ifc.req = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(posedge clk); #1;
            tests++;
            if (ifc.done !== 1'b0 || ifc.busy !== 1'b0 || ifc.k_vld !== 1'b0 || ifc.rnd !== 4'd15) begin
                fails++;
                $display("FAIL idle_after_done[%0d]: done=%b busy=%b k_vld=%b rnd=%0d, want 0 0 0 15",
                         j, ifc.done, ifc.busy, ifc.k_vld, ifc.rnd);
            end
        end
    endtask

    task automatic test_reset();
        ifc.req = 1'b0; ifc.dec = 1'b0; ifc.key = '0; ifc.nxt = 1'b0;
        rst = 1'b0;
        #1;
        tests++;
        if (ifc.k_vld !== 1'b0 || ifc.busy !== 1'b0 || ifc.done !== 1'b0 ||
            ifc.rnd !== 4'd0 || ifc.k !== 48'h0) begin
            fails++;
            $display("FAIL reset_state: k_vld=%b busy=%b done=%b rnd=%0d k=%h, want all 0",
                     ifc.k_vld, ifc.busy, ifc.done, ifc.rnd, ifc.k);
        end
        #12;
        @(posedge clk); #1;
        rst = 1'b1;
        ifc.req = 1'b1; ifc.key = KEY_A;
        @(posedge clk); #1;
        ifc.req = 1'b0; ifc.nxt = 1'b1;
        repeat (7) begin @(posedge clk); #1; end
        ifc.nxt = 1'b0;
        tests++;
        if (ifc.rnd !== 4'd7 || ifc.k_vld !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_rnd: rnd=%0d k_vld=%b, want 7 1", ifc.rnd, ifc.k_vld);
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if (ifc.k_vld !== 1'b0 || ifc.busy !== 1'b0 || ifc.rnd !== 4'd0 || ifc.k !== 48'h0) begin
            fails++;
            $display("FAIL async_reset: k_vld=%b busy=%b rnd=%0d k=%h, want 0 0 0 0",
                     ifc.k_vld, ifc.busy, ifc.rnd, ifc.k);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        do_run(KEY_A, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_encrypt();
        do_run(KEY_A, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 16; i++) seq_enc[i] = seq[i];
        tests++;
        if (seq[0] !== K1_A || seq[15] !== K16_A) begin
            fails++;
            $display("FAIL enc_golden: k0=%h k15=%h, want %h %h", seq[0], seq[15], K1_A, K16_A);
        end
    endtask

    task automatic test_decrypt();
        int bad;
        do_run(KEY_A, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        tests++;
        if (seq[0] !== K16_A || seq[15] !== K1_A) begin
            fails++;
            $display("FAIL dec_golden: k0=%h k15=%h, want %h %h", seq[0], seq[15], K16_A, K1_A);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (seq[i] !== seq_enc[15 - i]) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL dec_reverse: %0d keys differ from reversed encrypt run, want 0", bad);
        end
    endtask

    task automatic test_gaps();
        int bad;
        do_run(KEY_A, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        bad = 0;
        for (int i = 0; i < 16; i++) if (seq[i] !== seq_enc[i]) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL gaps_seq: %0d keys differ from continuous run, want 0", bad);
        end
    endtask

    task automatic test_ignore();
        do_run(KEY_A, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        do_run(64'h0E329232EA6D0D73, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic test_weak();
        do_run(64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 48'h0);
        do_run(64'hFEFEFEFEFEFEFEFE, 1'b0, 1'b0, 1'b0, 1'b1, 48'hFFFFFFFFFFFF);
        do_run(64'hFEFEFEFEFEFEFEFE, 1'b1, 1'b0, 1'b0, 1'b1, 48'hFFFFFFFFFFFF);
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_gaps();
        test_ignore();
        test_weak();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
